// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline types and constants.
// Used by the IF stage and its IF/ID register.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

  function automatic logic [XLEN-1:0] pc_inc(
    input logic [XLEN-1:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register.
// Load wins over bubble; neither set means hold.
module if_id_register
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  // register update: reset, load, bubble or hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q.pc       <= '0;
      q.pc_plus4 <= '0;
      q.instr    <= NOP_INSTR;
      q.valid    <= 1'b0;
    end else if (load) begin
      q <= d;
    end else if (bubble) begin
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32IM IF stage: PC, fetch FSM, skid buffer.
// Redirects may land while a fetch is in flight.
module instruction_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR    = NOP_WORD
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            STALL,
  input  logic            BRANCH_TAKEN,
  input  logic [XLEN-1:0] BRANCH_TARGET,
  output logic            IMEM_READ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_BUSYWAIT,
  input  logic [XLEN-1:0] IMEM_INSTRUCTION,
  output logic [XLEN-1:0] IF_ID_PC,
  output logic [XLEN-1:0] IF_ID_PC_PLUS4,
  output logic [XLEN-1:0] IF_ID_INSTRUCTION,
  output logic            IF_ID_VALID
);

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] disc_addr, disc_addr_n;
  if_id_t          skid, skid_n;

  logic            rd;
  logic            accept;
  logic            ld;
  logic            bub;
  logic [XLEN-1:0] target;
  if_id_t          ld_data;
  if_id_t          q;

  assign target = BRANCH_TARGET & ~32'd3;

  // state, PC, skid buffer and discard address
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= FETCH;
      pc        <= RESET_VECTOR;
      disc_addr <= RESET_VECTOR;
      skid      <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      disc_addr <= disc_addr_n;
      skid      <= skid_n;
    end
  end

  // next state, memory request and IF/ID controls
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    disc_addr_n = disc_addr;
    skid_n      = skid;
    rd          = 1'b0;
    IMEM_ADDR   = pc;
    ld          = 1'b0;
    bub         = 1'b0;
    ld_data     = '{pc:       pc,
                    pc_plus4: pc_inc(pc),
                    instr:    IMEM_INSTRUCTION,
                    valid:    1'b1};
    accept      = 1'b0;
    unique case (state)
      FETCH: begin
        rd     = 1'b1;
        accept = RESET_N & ~IMEM_BUSYWAIT;
        if (BRANCH_TAKEN) begin
          pc_n   = target;
          bub    = 1'b1;
          skid_n = '0;
          if (IMEM_BUSYWAIT) begin
            disc_addr_n = pc;
            state_n     = DISCARD;
          end
        end else if (accept && !STALL) begin
          ld   = 1'b1;
          pc_n = pc_inc(pc);
        end else if (accept) begin
          skid_n  = ld_data;
          state_n = HOLD;
        end else if (!STALL) begin
          bub = 1'b1;
        end
      end
      HOLD: begin
        if (BRANCH_TAKEN) begin
          pc_n    = target;
          bub     = 1'b1;
          skid_n  = '0;
          state_n = FETCH;
        end else if (!STALL) begin
          ld      = skid.valid;
          bub     = ~skid.valid;
          ld_data = skid;
          skid_n  = '0;
          pc_n    = pc_inc(pc);
          state_n = FETCH;
        end
      end
      DISCARD: begin
        rd        = 1'b1;
        IMEM_ADDR = disc_addr;
        bub       = 1'b1;
        if (BRANCH_TAKEN) begin
          pc_n = target;
        end
        if (!IMEM_BUSYWAIT) begin
          state_n = FETCH;
        end
      end
      default: begin
        state_n = FETCH;
      end
    endcase
  end

  assign IMEM_READ = rd & RESET_N;

  if_id_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .load   (ld),
    .bubble (bub),
    .d      (ld_data),
    .q      (q)
  );

  assign IF_ID_PC          = q.pc;
  assign IF_ID_PC_PLUS4    = q.pc_plus4;
  assign IF_ID_INSTRUCTION = q.instr;
  assign IF_ID_VALID       = q.valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed vector bench for instruction_fetch_unit.
// Memory returns a word derived from its address.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        br;
  logic [31:0] tgt;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic        busy;
  logic [31:0] imem_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_instr;
  logic        if_valid;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ {a[15:0], a[15:0]};
  endfunction

  assign imem_instr = word(imem_addr);

  instruction_fetch_unit dut (
    .CLK               (clk),
    .RESET_N           (rst_n),
    .STALL             (stall),
    .BRANCH_TAKEN      (br),
    .BRANCH_TARGET     (tgt),
    .IMEM_READ         (imem_read),
    .IMEM_ADDR         (imem_addr),
    .IMEM_BUSYWAIT     (busy),
    .IMEM_INSTRUCTION  (imem_instr),
    .IF_ID_PC          (if_pc),
    .IF_ID_PC_PLUS4    (if_pc4),
    .IF_ID_INSTRUCTION (if_instr),
    .IF_ID_VALID       (if_valid)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        busy;
    logic        exp_read;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[31];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic v,
                          input logic [31:0] p);
    chk({tag, " valid"}, {31'd0, if_valid}, {31'd0, v});
    chk({tag, " pc"}, if_pc, p);
    if (v) begin
      chk({tag, " pc4"}, if_pc4, p + 32'd4);
      chk({tag, " instr"}, if_instr, word(p));
    end else begin
      chk({tag, " instr"}, if_instr, NOP);
    end
  endtask

  initial begin
    vecs[0]  = '{0, 0, 0,     0, 1, 32'h000, 1, 32'h000};
    vecs[1]  = '{0, 0, 0,     0, 1, 32'h004, 1, 32'h004};
    vecs[2]  = '{0, 0, 0,     0, 1, 32'h008, 1, 32'h008};
    vecs[3]  = '{0, 0, 0,     0, 1, 32'h00C, 1, 32'h00C};
    vecs[4]  = '{0, 0, 0,     1, 1, 32'h010, 0, 32'h00C};
    vecs[5]  = '{0, 0, 0,     1, 1, 32'h010, 0, 32'h00C};
    vecs[6]  = '{0, 0, 0,     1, 1, 32'h010, 0, 32'h00C};
    vecs[7]  = '{0, 0, 0,     0, 1, 32'h010, 1, 32'h010};
    vecs[8]  = '{0, 0, 0,     0, 1, 32'h014, 1, 32'h014};
    vecs[9]  = '{0, 0, 0,     0, 1, 32'h018, 1, 32'h018};
    vecs[10] = '{0, 0, 0,     0, 1, 32'h01C, 1, 32'h01C};
    vecs[11] = '{1, 0, 0,     0, 1, 32'h020, 1, 32'h01C};
    vecs[12] = '{1, 0, 0,     0, 0, 32'h000, 1, 32'h01C};
    vecs[13] = '{0, 0, 0,     0, 0, 32'h000, 1, 32'h020};
    vecs[14] = '{0, 0, 0,     0, 1, 32'h024, 1, 32'h024};
    vecs[15] = '{0, 1, 32'h103, 0, 1, 32'h028, 0, 32'h024};
    vecs[16] = '{0, 0, 0,     0, 1, 32'h100, 1, 32'h100};
    vecs[17] = '{0, 0, 0,     0, 1, 32'h104, 1, 32'h104};
    vecs[18] = '{0, 1, 32'h040, 0, 1, 32'h108, 0, 32'h104};
    vecs[19] = '{0, 1, 32'h200, 1, 1, 32'h040, 0, 32'h104};
    vecs[20] = '{0, 0, 0,     1, 1, 32'h040, 0, 32'h104};
    vecs[21] = '{0, 0, 0,     0, 1, 32'h040, 0, 32'h104};
    vecs[22] = '{0, 0, 0,     0, 1, 32'h200, 1, 32'h200};
    vecs[23] = '{1, 1, 32'h300, 0, 1, 32'h204, 0, 32'h200};
    vecs[24] = '{0, 0, 0,     0, 1, 32'h300, 1, 32'h300};
    vecs[25] = '{0, 1, 32'h400, 1, 1, 32'h304, 0, 32'h300};
    vecs[26] = '{0, 1, 32'h500, 1, 1, 32'h304, 0, 32'h300};
    vecs[27] = '{0, 0, 0,     0, 1, 32'h304, 0, 32'h300};
    vecs[28] = '{0, 0, 0,     0, 1, 32'h500, 1, 32'h500};
    vecs[29] = '{1, 0, 0,     1, 1, 32'h504, 1, 32'h500};
    vecs[30] = '{0, 0, 0,     0, 1, 32'h504, 1, 32'h504};

    rst_n = 1'b0;
    stall = 1'b0;
    br    = 1'b0;
    tgt   = '0;
    busy  = 1'b0;

    step();
    chk("rst read", {31'd0, imem_read}, 32'd0);
    step();
    chk("rst pc4", if_pc4, 32'd0);
    chk_ifid("rst", 1'b0, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 31; i++) begin
      stall = vecs[i].stall;
      br    = vecs[i].br;
      tgt   = vecs[i].tgt;
      busy  = vecs[i].busy;
      #1;
      chk($sformatf("v%0d read", i), {31'd0, imem_read},
          {31'd0, vecs[i].exp_read});
      if (vecs[i].exp_read)
        chk($sformatf("v%0d addr", i), imem_addr, vecs[i].exp_addr);
      step();
      chk_ifid($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
    end

    stall = 1'b0;
    br    = 1'b1;
    tgt   = 32'hFFFF_FFFF;
    busy  = 1'b0;
    step();
    br = 1'b0;
    #1;
    chk("wrap addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap pc4", if_pc4, 32'h0000_0000);
    chk("wrap valid", {31'd0, if_valid}, 32'd1);
    chk("wrap addr1", imem_addr, 32'h0000_0000);

    stall = 1'b1;
    step();
    chk("hold read", {31'd0, imem_read}, 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    stall = 1'b0;
    #1;
    chk("hrst read", {31'd0, imem_read}, 32'd1);
    chk("hrst addr", imem_addr, 32'd0);
    chk_ifid("hrst", 1'b0, 32'd0);
    step();
    chk_ifid("hrst fetch", 1'b1, 32'd0);

    busy = 1'b1;
    br   = 1'b1;
    tgt  = 32'h600;
    step();
    br = 1'b0;
    #1;
    chk("disc addr", imem_addr, 32'h004);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    busy  = 1'b0;
    #1;
    chk("drst addr", imem_addr, 32'd0);
    chk("drst pc4", if_pc4, 32'd0);
    chk_ifid("drst", 1'b0, 32'd0);
    step();
    chk_ifid("drst fetch", 1'b1, 32'd0);
    chk("drst next", imem_addr, 32'h004);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
IF stage of the RV32IM pipeline.
- Holds the PC and fetches one 32-bit instruction per accepted instruction-memory transaction.
- Drives the IF/ID pipeline register that feeds decode, register file and immediate generation.
- Handles hazard-unit stalls, EX-stage redirects (taken branch/JAL/JALR) and multi-cycle memory waits, including redirects that land while a fetch is in flight.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, instruction driven on IF_ID_INSTRUCTION for bubbles (ADDI x0,x0,0).

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RESET_N  input  1  synchronous, active-low reset; sampled on the rising edge of CLK.
STALL  input  1  hazard unit: hold IF/ID and PC.
BRANCH_TAKEN  input  1  EX-stage redirect pulse.
BRANCH_TARGET  input  32  redirect address.
IMEM_READ  output  1  fetch request.
IMEM_ADDR  output  32  fetch address; stable while IMEM_READ=1 and IMEM_BUSYWAIT=1.
IMEM_BUSYWAIT  input  1  memory not ready; instruction valid when IMEM_READ=1 and IMEM_BUSYWAIT=0.
IMEM_INSTRUCTION  input  32  fetched word.
IF_ID_PC  output  32  PC of the instruction in IF/ID.
IF_ID_PC_PLUS4  output  32  IF_ID_PC+4 (JAL/JALR link value).
IF_ID_INSTRUCTION  output  32  instruction to decode.
IF_ID_VALID  output  1  IF/ID holds a real instruction.

Behaviour:
- Accept = IMEM_READ & ~IMEM_BUSYWAIT (same cycle).
- Reset (RESET_N=0 at an edge, any state):
  - PC=RESET_VECTOR, state FETCH, skid buffer empty.
  - IF_ID_PC=0, IF_ID_PC_PLUS4=0, IF_ID_INSTRUCTION=NOP_INSTR, IF_ID_VALID=0.
  - IMEM_READ=0 while RESET_N=0.
  - Any in-flight fetch is abandoned; the memory tolerates request drop on reset.
- States: FETCH, HOLD, DISCARD.
- FETCH:
  - Outputs: IMEM_READ=1, IMEM_ADDR=PC.
  - Accept & ~STALL: IF/ID <= {PC, PC+4, IMEM_INSTRUCTION, 1}; PC <= PC+4. Zero-wait memory gives one instruction per cycle; latency request-to-IF/ID = 1 edge.
  - Accept & STALL: word and PC go into the skid buffer; IF/ID unchanged; go to HOLD.
  - No accept & ~STALL: IF/ID <= bubble (NOP_INSTR, VALID=0, PCs unchanged).
  - No accept & STALL: IF/ID unchanged.
- HOLD:
  - IMEM_READ=0.
  - While STALL=1: IF/ID and buffer unchanged.
  - When STALL=0: IF/ID <= buffer; PC <= PC+4; go to FETCH.
- Redirect (BRANCH_TAKEN=1) has priority over STALL and accept in every state:
  - PC <= {BRANCH_TARGET[31:2], 2'b00}.
  - IF/ID <= bubble even if STALL=1.
  - Skid buffer cleared.
  - If in FETCH with IMEM_BUSYWAIT=1 (fetch in flight): go to DISCARD. Otherwise go to FETCH.
- DISCARD:
  - IMEM_READ=1 and IMEM_ADDR = old address, held in a separate register so the new PC does not disturb the address.
  - On accept: drop the word, go to FETCH at the new PC.
  - A second BRANCH_TAKEN while in DISCARD overwrites PC; stay in DISCARD.
  - IF/ID remains bubble.
- Arithmetic: PC+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000). No misalignment trap.
- Simultaneous STALL, accept and BRANCH_TAKEN: redirect wins; the accepted word is dropped.

Decomposition:
- Shared package (rv32_pkg): NOP_INSTR, RESET_VECTOR default, IF/ID field widths, fetch state encoding constants.
- Natural sub-module: if_id_register (IF/ID flops with load/hold/bubble controls).
- Fetch FSM, PC and skid buffer stay in the top module.

Test Plan:
- Reset, zero-wait memory, no stalls: IF_ID_PC = 0x0, 0x4, 0x8 on consecutive edges, VALID=1; IF_ID_PC_PLUS4 = 0x4, 0x8, 0xC.
- BUSYWAIT high 3 cycles at PC=0x10: IMEM_ADDR stays 0x10, three bubbles (VALID=0, NOP_INSTR), then IF_ID_PC=0x10 with the returned word.
- STALL asserted in the accept cycle for 2 cycles at PC=0x20: IF/ID holds its old entry, IMEM_READ=0, then IF_ID_PC=0x20 and fetch resumes at 0x24.
- BRANCH_TAKEN target 0x103 in FETCH with zero wait: next IF/ID is a bubble, IMEM_ADDR=0x100 the following cycle.
- BRANCH_TAKEN (target 0x200) while the fetch of 0x40 is busy: IMEM_ADDR stays 0x40 until accept, that word never reaches IF/ID, then IMEM_ADDR=0x200.
- RESET_N low in DISCARD or HOLD: after release IMEM_ADDR=RESET_VECTOR, VALID=0, buffer empty; PC 0xFFFF_FFFC wraps to 0x0.
